// File: rtl/conv_bcd_seq.sv
// Sequential 8-bit binary to BCD converter (shift-and-add-3), one bit per cycle.
// Optional: define CONV_BCD_SEQ_AUTO_EN to start conversions whenever entrada changes.
module conv_bcd_seq (
    input  logic       reloj,
    input  logic       reset,
    input  logic [7:0] entrada,
    input  logic       inicio,
    output logic       ocupado,
    output logic       valido,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [1:0] hunds
);

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] u_q, u_d, t_q, t_d;
    logic [1:0] h_q, h_d;
    logic [3:0] units_q, units_d, tens_q, tens_d;
    logic [1:0] hunds_q, hunds_d;
    logic       valido_q, valido_d;
    logic [3:0] u_adj, t_adj;
    logic       start;

`ifdef CONV_BCD_SEQ_AUTO_EN
    logic [7:0] last_q, last_d;
    assign start = (entrada != last_q);

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) last_q <= 8'd0;
        else       last_q <= last_d;
    end
`else
    assign start = inicio;
`endif

    // Hundreds never reaches 5 for an 8-bit input, so only units/tens need the add-3.
    assign u_adj = (u_q >= 4'd5) ? u_q + 4'd3 : u_q;
    assign t_adj = (t_q >= 4'd5) ? t_q + 4'd3 : t_q;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        u_d      = u_q;
        t_d      = t_q;
        h_d      = h_q;
        units_d  = units_q;
        tens_d   = tens_q;
        hunds_d  = hunds_q;
        valido_d = 1'b0;
`ifdef CONV_BCD_SEQ_AUTO_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = entrada;
                    cnt_d   = 3'd0;
                    u_d     = 4'd0;
                    t_d     = 4'd0;
                    h_d     = 2'd0;
                    state_d = CONV;
`ifdef CONV_BCD_SEQ_AUTO_EN
                    last_d  = entrada;
`endif
                end
            end
            CONV: begin
                h_d  = {h_q[0], t_adj[3]};
                t_d  = {t_adj[2:0], u_adj[3]};
                u_d  = {u_adj[2:0], sr_q[7]};
                sr_d = {sr_q[6:0], 1'b0};
                // Counter holds at 7 on the last shift; leaving CONV stops further shifts.
                if (cnt_q == 3'd7) state_d = FIN;
                else               cnt_d   = cnt_q + 3'd1;
            end
            FIN: begin
                units_d  = u_q;
                tens_d   = t_q;
                hunds_d  = h_q;
                valido_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= 8'd0;
            cnt_q    <= 3'd0;
            u_q      <= 4'd0;
            t_q      <= 4'd0;
            h_q      <= 2'd0;
            units_q  <= 4'd0;
            tens_q   <= 4'd0;
            hunds_q  <= 2'd0;
            valido_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            u_q      <= u_d;
            t_q      <= t_d;
            h_q      <= h_d;
            units_q  <= units_d;
            tens_q   <= tens_d;
            hunds_q  <= hunds_d;
            valido_q <= valido_d;
        end
    end

    assign ocupado = (state_q != IDLE);
    assign valido  = valido_q;
    assign units   = units_q;
    assign tens    = tens_q;
    assign hunds   = hunds_q;

`ifdef CONV_BCD_SEQ_AUTO_EN
    logic unused_inicio;
    assign unused_inicio = inicio;
`endif

endmodule
